if_fetch_unit: RTL and testbench
================================

Name: if_fetch_unit

Overview:
Instruction-fetch front end sitting directly upstream of the IF/ID pipeline register.
- Owns the PC and issues one-at-a-time requests to a variable-latency instruction memory (cache port).
- Buffers returned words in a small FIFO and presents {pc_plus_four, instruction} to the IF stage register.
- Handles branch redirect, including squashing an in-flight fetch, and hazard freeze.

Parameters:
- FIFO_DEPTH, 2, fetch buffer entries (power of two, ≥2).
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset, asynchronous, active-low.
- freeze  in  1  hazard stall from downstream; inhibits FIFO pop.
- branch_taken  in  1  redirect pulse from EX.
- branch_address  in  32  redirect target.
- imem_req  out  1  fetch request; held until imem_ack.
- imem_addr  out  32  word address of request; stable while imem_req=1.
- imem_ack  in  1  one-cycle response strobe; imem_rdata valid this cycle.
- imem_rdata  in  32  fetched instruction.
- pc_plus_four_out  out  32  FIFO head address+4, or 0 when empty.
- instruction_out  out  32  FIFO head instruction, or 0 (bubble) when empty.
- fetch_empty  out  1  FIFO empty (bubble presented).
- perf_stall_cnt  out  32  empty-and-not-frozen cycles (see Optional Feature).
- perf_squash_cnt  out  32  squashed fetches (see Optional Feature).

Behaviour:
- **Reset** (rst=0, asynchronous):
  - state=IDLE, fetch_addr=RESET_PC, FIFO count=0.
  - All outputs 0; imem_req drops immediately.
  - The memory side must tolerate an abandoned request.
- **States and request signalling:**
  - States: IDLE, WAIT, WAIT_SQUASH.
  - imem_req = (state != IDLE).
  - imem_addr = fetch_addr.
- **Pop:**
  - pop = !freeze && !branch_taken && count>0.
  - Outputs are combinational from the FIFO head; count=0 gives zeros and fetch_empty=1.
- **Space:** space = (count - pop + push) < FIFO_DEPTH, evaluated on post-update occupancy.
- **IDLE:**
  - branch_taken: fetch_addr<=branch_address, stay IDLE.
  - Else, if count<FIFO_DEPTH: go WAIT.
- **WAIT, imem_ack=1 and branch_taken=0:**
  - push {fetch_addr+4, imem_rdata}; fetch_addr+=4.
  - Stay WAIT if space, else go IDLE.
- **WAIT, branch_taken=1:**
  - FIFO cleared, fetch_addr<=branch_address, ack data (if any) discarded.
  - With ack in the same cycle: go IDLE.
  - Without ack: go WAIT_SQUASH.
- **WAIT_SQUASH:**
  - imem_req stays high with the old address latched in a separate squash register. imem_addr must not change until ack.
  - On imem_ack: data dropped, go IDLE.
  - A further branch_taken updates fetch_addr and clears the FIFO, staying in WAIT_SQUASH.
- **Priorities:**
  - branch_taken dominates freeze and any push.
  - Push and pop in the same cycle are legal; count is unchanged.
- **Ordering:**
  - At most one outstanding request.
  - Instructions leave in fetch order.
  - fetch_addr wraps modulo 2^32.
  - imem_ack while IDLE is a protocol error and is ignored.

Optional Feature:
- **Macro FETCH_PERF_CNT_EN.**
- **Defined:**
  - perf_stall_cnt increments each cycle fetch_empty=1 && freeze=0.
  - perf_squash_cnt increments on each entry into WAIT_SQUASH and each same-cycle ack+branch drop.
  - Both counters are 32-bit, wrap, and are cleared by rst.
- **Undefined:** both ports tied to 0, no counter flops.

Test Plan:
1. Reset release, memory acks in the same cycle as req:
   - Cycle 1 imem_req=1 with addr 0x0.
   - Outputs then show pc_plus_four 0x4, 0x8, 0xC on consecutive cycles with rdata passed through.
   - fetch_empty=0 from cycle 2.
2. 3-cycle ack latency, freeze=0:
   - Each address is held for 3 cycles.
   - Bubbles (instruction_out=0, fetch_empty=1) appear between instructions.
3. freeze=1 for 6 cycles:
   - FIFO fills to 2, then imem_req drops (IDLE).
   - The head word is held unchanged.
   - After freeze drops, fetching resumes at the next sequential address.
4. branch_taken with target 0x100 while WAIT on addr 0x10 without ack:
   - WAIT_SQUASH; imem_addr stays 0x10 until ack.
   - The ack data is dropped.
   - The next request has addr 0x100 and the first output has pc_plus_four 0x104.
5. branch_taken in the same cycle as imem_ack:
   - The acked word is not pushed, FIFO is cleared, next request goes to the target.
   - perf_squash_cnt += 1 when FETCH_PERF_CNT_EN is defined.
6. rst asserted mid-WAIT:
   - imem_req and all outputs go 0 asynchronously.
   - After release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end. It owns the PC, keeps at most one imem request in flight and buffers fetched words in a FIFO.
// Performance counters are built only when FETCH_PERF_CNT_EN is defined; otherwise both perf ports are tied to zero.
module if_fetch_unit #(
  parameter int unsigned FIFO_DEPTH = 2,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_address,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_plus_four_out,
  output logic [31:0] instruction_out,
  output logic        fetch_empty,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_squash_cnt
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  localparam logic [1:0] ST_IDLE        = 2'd0;
  localparam logic [1:0] ST_WAIT        = 2'd1;
  localparam logic [1:0] ST_WAIT_SQUASH = 2'd2;

  logic [1:0]       state, state_nxt;
  logic [31:0]      fetch_addr, fetch_addr_nxt;
  logic [31:0]      squash_addr;
  logic             squash_load;

  logic [31:0]      pc_mem  [FIFO_DEPTH];
  logic [31:0]      ins_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count, count_after;
  logic             pop, push;

  assign pop         = !freeze && !branch_taken && (count != '0);
  assign push        = (state == ST_WAIT) && imem_ack && !branch_taken;
  assign count_after = count - CNT_W'(pop) + CNT_W'(push);

  always_comb begin
    state_nxt      = state;
    fetch_addr_nxt = fetch_addr;
    squash_load    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (branch_taken) begin
          fetch_addr_nxt = branch_address;
        end else if (count < DEPTH_C) begin
          state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (branch_taken) begin
          fetch_addr_nxt = branch_address;
          if (imem_ack) begin
            state_nxt = ST_IDLE;
          end else begin
            state_nxt   = ST_WAIT_SQUASH;
            squash_load = 1'b1;
          end
        end else if (imem_ack) begin
          fetch_addr_nxt = fetch_addr + 32'd4;
          state_nxt      = (count_after < DEPTH_C) ? ST_WAIT : ST_IDLE;
        end
      end
      ST_WAIT_SQUASH: begin
        if (branch_taken) fetch_addr_nxt = branch_address;
        if (imem_ack) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      fetch_addr  <= RESET_PC;
      squash_addr <= RESET_PC;
    end else begin
      state      <= state_nxt;
      fetch_addr <= fetch_addr_nxt;
      if (squash_load) squash_addr <= fetch_addr;
    end
  end

  // A redirect flushes the buffer in every state, so stale words never follow a taken branch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (branch_taken) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_after;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]  <= fetch_addr + 32'd4;
      ins_mem[wr_ptr] <= imem_rdata;
    end
  end

  assign imem_req         = (state != ST_IDLE);
  assign imem_addr        = (state == ST_WAIT_SQUASH) ? squash_addr : fetch_addr;
  assign fetch_empty      = (count == '0);
  assign pc_plus_four_out = fetch_empty ? '0 : pc_mem[rd_ptr];
  assign instruction_out  = fetch_empty ? '0 : ins_mem[rd_ptr];

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cnt, squash_cnt;

  // A branch in WAIT either abandons the request or drops the data acked in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt  <= '0;
      squash_cnt <= '0;
    end else begin
      if (fetch_empty && !freeze) stall_cnt <= stall_cnt + 32'd1;
      if ((state == ST_WAIT) && branch_taken) squash_cnt <= squash_cnt + 32'd1;
    end
  end

  assign perf_stall_cnt  = stall_cnt;
  assign perf_squash_cnt = squash_cnt;
`else
  assign perf_stall_cnt  = '0;
  assign perf_squash_cnt = '0;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed vector table, hand sequences for squash/freeze/reset, and random traffic checked against a queue model.
module tb_if_fetch_unit;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        freeze = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_address = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] pc_plus_four_out;
  logic [31:0] instruction_out;
  logic        fetch_empty;
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_squash_cnt;

  if_fetch_unit #(.FIFO_DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
    .clk              (clk),
    .rst              (rst),
    .freeze           (freeze),
    .branch_taken     (branch_taken),
    .branch_address   (branch_address),
    .imem_req         (imem_req),
    .imem_addr        (imem_addr),
    .imem_ack         (imem_ack),
    .imem_rdata       (imem_rdata),
    .pc_plus_four_out (pc_plus_four_out),
    .instruction_out  (instruction_out),
    .fetch_empty      (fetch_empty),
    .perf_stall_cnt   (perf_stall_cnt),
    .perf_squash_cnt  (perf_squash_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: an outstanding-request flag, a "dead" flag for abandoned requests, and a queue of fetched words.
  typedef struct { logic [31:0] pc4; logic [31:0] ins; } ent_t;
  ent_t        q[$];
  logic        m_busy, m_dead;
  logic [31:0] m_next, m_sq_addr;
  logic [31:0] m_stall, m_squash;

  task automatic model_reset();
    q.delete();
    m_busy = 1'b0; m_dead = 1'b0;
    m_next = 32'h0; m_sq_addr = 32'h0;
    m_stall = '0; m_squash = '0;
  endtask

  task automatic model_step(input logic f, input logic b, input logic [31:0] ba,
                            input logic a, input logic [31:0] rd);
    int n0;
    n0 = q.size();
    if (n0 == 0 && !f) m_stall++;
    if (b) begin
      if (m_busy && !m_dead) begin
        m_squash++;
        if (a) m_busy = 1'b0;
        else begin m_dead = 1'b1; m_sq_addr = m_next; end
      end else if (m_busy && m_dead && a) begin
        m_busy = 1'b0; m_dead = 1'b0;
      end
      m_next = ba;
      q.delete();
    end else begin
      if (!f && n0 > 0) void'(q.pop_front());
      if (m_busy) begin
        if (a) begin
          if (m_dead) begin
            m_busy = 1'b0; m_dead = 1'b0;
          end else begin
            q.push_back('{pc4: m_next + 32'd4, ins: rd});
            m_next = m_next + 32'd4;
            if (q.size() >= DEPTH) m_busy = 1'b0;
          end
        end
      end else if (n0 < DEPTH) begin
        m_busy = 1'b1;
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [31:0] e_pc, e_ins, e_stall, e_squash;
    e_pc  = (q.size() == 0) ? 32'h0 : q[0].pc4;
    e_ins = (q.size() == 0) ? 32'h0 : q[0].ins;
`ifdef FETCH_PERF_CNT_EN
    e_stall = m_stall; e_squash = m_squash;
`else
    e_stall = 32'h0; e_squash = 32'h0;
`endif
    chk({tag, ".imem_req"},    32'(imem_req), 32'(m_busy));
    if (m_busy) chk({tag, ".imem_addr"}, imem_addr, m_dead ? m_sq_addr : m_next);
    chk({tag, ".fetch_empty"}, 32'(fetch_empty), 32'(q.size() == 0));
    chk({tag, ".pc4"},         pc_plus_four_out, e_pc);
    chk({tag, ".instr"},       instruction_out, e_ins);
    chk({tag, ".stall_cnt"},   perf_stall_cnt, e_stall);
    chk({tag, ".squash_cnt"},  perf_squash_cnt, e_squash);
  endtask

  // Called at a falling edge: drive inputs, advance the model, then check after the rising edge.
  task automatic step(input string tag, input logic f, input logic b, input logic [31:0] ba,
                      input logic a, input logic [31:0] rd);
    freeze = f; branch_taken = b; branch_address = ba; imem_ack = a; imem_rdata = rd;
    model_step(f, b, ba, a, rd);
    @(posedge clk);
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".req"},    32'(imem_req), 32'h0);
    chk({tag, ".addr"},   imem_addr, 32'h0);
    chk({tag, ".pc4"},    pc_plus_four_out, 32'h0);
    chk({tag, ".instr"},  instruction_out, 32'h0);
    chk({tag, ".empty"},  32'(fetch_empty), 32'h1);
    chk({tag, ".stall"},  perf_stall_cnt, 32'h0);
    chk({tag, ".squash"}, perf_squash_cnt, 32'h0);
  endtask

  typedef struct {
    logic frz; logic br; logic [31:0] ba; logic ack; logic [31:0] rd;
    logic e_req; logic [31:0] e_addr; logic e_empty; logic [31:0] e_pc; logic [31:0] e_ins;
  } vec_t;
  vec_t tbl [11];

  initial begin
    tbl[0]  = '{1'b0, 1'b0, 32'h0, 1'b0, 32'h0,         1'b1, 32'h00, 1'b1, 32'h00, 32'h0};
    tbl[1]  = '{1'b0, 1'b0, 32'h0, 1'b1, 32'h1111_1111, 1'b1, 32'h04, 1'b0, 32'h04, 32'h1111_1111};
    tbl[2]  = '{1'b0, 1'b0, 32'h0, 1'b1, 32'h2222_2222, 1'b1, 32'h08, 1'b0, 32'h08, 32'h2222_2222};
    tbl[3]  = '{1'b0, 1'b0, 32'h0, 1'b1, 32'h3333_3333, 1'b1, 32'h0C, 1'b0, 32'h0C, 32'h3333_3333};
    tbl[4]  = '{1'b0, 1'b0, 32'h0, 1'b0, 32'h0,         1'b1, 32'h0C, 1'b1, 32'h00, 32'h0};
    tbl[5]  = '{1'b0, 1'b0, 32'h0, 1'b0, 32'h0,         1'b1, 32'h0C, 1'b1, 32'h00, 32'h0};
    tbl[6]  = '{1'b0, 1'b0, 32'h0, 1'b1, 32'h4444_4444, 1'b1, 32'h10, 1'b0, 32'h10, 32'h4444_4444};
    tbl[7]  = '{1'b0, 1'b0, 32'h0, 1'b0, 32'h0,         1'b1, 32'h10, 1'b1, 32'h00, 32'h0};
    tbl[8]  = '{1'b0, 1'b0, 32'h0, 1'b0, 32'h0,         1'b1, 32'h10, 1'b1, 32'h00, 32'h0};
    tbl[9]  = '{1'b0, 1'b0, 32'h0, 1'b1, 32'h5555_5555, 1'b1, 32'h14, 1'b0, 32'h14, 32'h5555_5555};
    tbl[10] = '{1'b0, 1'b0, 32'h0, 1'b0, 32'h0,         1'b1, 32'h14, 1'b1, 32'h00, 32'h0};

    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b1;

    // Same-cycle acks, then 3-cycle latency with bubbles
    for (int i = 0; i < 11; i++) begin
      step($sformatf("tbl%0d", i), tbl[i].frz, tbl[i].br, tbl[i].ba, tbl[i].ack, tbl[i].rd);
      chk($sformatf("tbl%0d.req", i),   32'(imem_req), 32'(tbl[i].e_req));
      chk($sformatf("tbl%0d.addr", i),  imem_addr, tbl[i].e_addr);
      chk($sformatf("tbl%0d.empty", i), 32'(fetch_empty), 32'(tbl[i].e_empty));
      chk($sformatf("tbl%0d.pc4", i),   pc_plus_four_out, tbl[i].e_pc);
      chk($sformatf("tbl%0d.instr", i), instruction_out, tbl[i].e_ins);
    end

    // Freeze: FIFO fills, request drops, head held, fetch resumes at 0x1C
    step("frz1", 1'b1, 1'b0, 32'h0, 1'b1, 32'hA0A0_A0A0);
    step("frz2", 1'b1, 1'b0, 32'h0, 1'b1, 32'hB0B0_B0B0);
    chk("frz2.req_dropped", 32'(imem_req), 32'h0);
    step("frz3", 1'b1, 1'b0, 32'h0, 1'b1, 32'hEEEE_EEEE);
    step("frz4", 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    step("frz5", 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    step("frz6", 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("frz6.head_pc4", pc_plus_four_out, 32'h18);
    chk("frz6.head_ins", instruction_out, 32'hA0A0_A0A0);
    step("frz7", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("frz7.next_ins", instruction_out, 32'hB0B0_B0B0);
    step("frz8", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("frz8.resume_addr", imem_addr, 32'h1C);
    chk("frz8.resume_req", 32'(imem_req), 32'h1);

    // Branch while waiting without ack: old address held until the dropped ack
    step("sq1", 1'b0, 1'b1, 32'h100, 1'b0, 32'h0);
    chk("sq1.addr_held", imem_addr, 32'h1C);
    step("sq2", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("sq2.addr_held", imem_addr, 32'h1C);
    step("sq3", 1'b0, 1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF);
    chk("sq3.dropped", 32'(fetch_empty), 32'h1);
    step("sq4", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("sq4.target_addr", imem_addr, 32'h100);
    step("sq5", 1'b0, 1'b0, 32'h0, 1'b1, 32'hCAFE_0001);
    chk("sq5.pc4", pc_plus_four_out, 32'h104);

    // Branch in the same cycle as ack
    step("sa1", 1'b0, 1'b1, 32'h200, 1'b1, 32'hBAD0_BAD0);
    chk("sa1.empty", 32'(fetch_empty), 32'h1);
    chk("sa1.req", 32'(imem_req), 32'h0);
`ifdef FETCH_PERF_CNT_EN
    chk("sa1.squash_cnt", perf_squash_cnt, 32'd2);
`endif
    step("sa2", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("sa2.target_addr", imem_addr, 32'h200);

    // Asynchronous reset in the middle of WAIT
    step("rs0", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    #2 rst = 1'b0;
    #1 chk_reset_outputs("async_rst");
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    step("rs1", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("rs1.addr", imem_addr, 32'h0);
    step("rs2", 1'b0, 1'b0, 32'h0, 1'b1, 32'h7777_0000);
    chk("rs2.pc4", pc_plus_four_out, 32'h4);

    // Random traffic, including redirects near the 2^32 wrap and spurious idle acks
    for (int i = 0; i < 4000; i++) begin
      logic f, b, a;
      logic [31:0] ba;
      f  = ($urandom_range(0, 9) < 3);
      b  = ($urandom_range(0, 15) == 0);
      ba = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF4 : ($urandom() & 32'hFFFF_FFFC);
      a  = m_busy ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
      step("rnd", f, b, ba, a, $urandom());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
